// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Producer side of the decoder's instruction interface. Fetches DATA_W-bit
// words from program memory, buffers them with their addresses in a small
// prefetch FIFO, and presents the FIFO head to the decoder. A redirect
// (load_pc/new_pc) clears the FIFO and restarts fetch at new_pc. A response
// still in flight when the redirect arrives is waited out in the FLUSH
// state and then thrown away.
//
// Ports:
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   MEM_req    out  1       fetch request to program memory
//   MEM_addr   out  ADDR_W  fetch address, stable while MEM_req=1 until MEM_ack
//   MEM_ack    in   1       one-cycle pulse: MEM_data valid, request complete
//   MEM_data   in   DATA_W  instruction word from memory
//   INS        out  DATA_W  FIFO head word
//   INS_addr   out  ADDR_W  address of INS
//   INS_valid  out  1       FIFO not empty
//   INS_ready  in   1       consumer accepts INS this cycle
//   load_pc    in   1       redirect request
//   new_pc     in   ADDR_W  redirect target
//   stall_cnt  out  16      (IFU_PERF_CNT_EN only) saturating count of cycles
//                           with INS_valid=0 and INS_ready=1
//
// Optional build macro: IFU_PERF_CNT_EN adds the stall_cnt port and counter.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned        ADDR_W     = 16,
    parameter int unsigned        DATA_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int unsigned        FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // program memory
    output logic              MEM_req,
    output logic [ADDR_W-1:0] MEM_addr,
    input  logic              MEM_ack,
    input  logic [DATA_W-1:0] MEM_data,
    // decoder side
    output logic [DATA_W-1:0] INS,
    output logic [ADDR_W-1:0] INS_addr,
    output logic              INS_valid,
    input  logic              INS_ready,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] new_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        StFetch,
        StFlush
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             r_state_q,    r_state_d;
    logic [ADDR_W-1:0]  r_fetch_pc_q, r_fetch_pc_d;
    logic               r_req_q,      r_req_d;
    logic [ADDR_W-1:0]  r_mem_addr_q, r_mem_addr_d;
    logic [PTR_W-1:0]   r_wr_ptr_q,   r_wr_ptr_d;
    logic [PTR_W-1:0]   r_rd_ptr_q,   r_rd_ptr_d;
    logic [CNT_W-1:0]   r_count_q,    r_count_d;

    logic [ADDR_W-1:0]  r_fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data_q [FIFO_DEPTH];

    logic               w_ack;
    logic               w_hold;
    logic               w_push;
    logic               w_pop;

    // An ack only means something while our request is up.
    assign w_ack  = MEM_ack & r_req_q;
    // Request outstanding and not completing this cycle: keep it on the bus.
    assign w_hold = r_req_q & ~w_ack;
    // Redirect takes priority: neither the acked word nor the head is consumed.
    assign w_push = w_ack & (r_state_q == StFetch) & ~load_pc;
    assign w_pop  = (r_count_q != '0) & INS_ready & ~load_pc;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        r_state_d    = r_state_q;
        r_fetch_pc_d = r_fetch_pc_q;
        r_wr_ptr_d   = r_wr_ptr_q;
        r_rd_ptr_d   = r_rd_ptr_q;
        r_count_d    = r_count_q;

        if (load_pc) begin
            r_fetch_pc_d = new_pc;
            r_count_d    = '0;
            // Empty the FIFO without moving the head pointer so INS keeps
            // showing the last head value while invalid.
            r_wr_ptr_d   = r_rd_ptr_q;
            // A request still in flight must be waited out and discarded.
            r_state_d    = w_hold ? StFlush : StFetch;
        end else begin
            unique case (r_state_q)
                StFetch: begin
                    if (w_push) begin
                        r_fetch_pc_d = r_fetch_pc_q + ADDR_W'(1);
                        r_wr_ptr_d   = r_wr_ptr_q + PTR_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
                    end
                    unique case ({w_push, w_pop})
                        2'b10:   r_count_d = r_count_q + CNT_W'(1);
                        2'b01:   r_count_d = r_count_q - CNT_W'(1);
                        default: r_count_d = r_count_q;
                    endcase
                end
                StFlush: begin
                    // FIFO is already empty here, so nothing can pop.
                    if (w_ack) begin
                        r_state_d = StFetch;
                    end
                end
                default: r_state_d = StFetch;
            endcase
        end

        // After an ack nothing is outstanding, so only the FIFO fill counts.
        r_req_d      = w_hold | ((r_state_d == StFetch) && (r_count_d < DEPTH_C));
        r_mem_addr_d = w_hold ? r_mem_addr_q : r_fetch_pc_d;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= StFetch;
            r_fetch_pc_q <= RESET_PC;
            r_req_q      <= 1'b0;
            r_mem_addr_q <= RESET_PC;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
        end else begin
            r_state_q    <= r_state_d;
            r_fetch_pc_q <= r_fetch_pc_d;
            r_req_q      <= r_req_d;
            r_mem_addr_q <= r_mem_addr_d;
            r_wr_ptr_q   <= r_wr_ptr_d;
            r_rd_ptr_q   <= r_rd_ptr_d;
            r_count_q    <= r_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_addr_q <= '{default: '0};
            r_fifo_data_q <= '{default: '0};
        end else if (w_push) begin
            r_fifo_addr_q[r_wr_ptr_q] <= r_mem_addr_q;
            r_fifo_data_q[r_wr_ptr_q] <= MEM_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign MEM_req   = r_req_q;
    assign MEM_addr  = r_mem_addr_q;
    assign INS       = r_fifo_data_q[r_rd_ptr_q];
    assign INS_addr  = r_fifo_addr_q[r_rd_ptr_q];
    assign INS_valid = (r_count_q != '0);

`ifdef IFU_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Stall counter: consumer ready but nothing to hand over.
    // ------------------------------------------------------------------------
    logic [15:0] r_stall_cnt_q;
    logic        w_stall;

    assign w_stall = (r_count_q == '0) & INS_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt_q <= '0;
        end else if (w_stall && (r_stall_cnt_q != 16'hFFFF)) begin
            r_stall_cnt_q <= r_stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed latency/boundary scenarios followed by a randomized phase. Memory
// returns mem[a] = a ^ 16'hA5A5 after a configurable number of wait states.
// The reference model treats the accepted instruction stream abstractly: the
// next accepted address is the reset PC or the most recent redirect target,
// incremented by one (mod 2^16) per accepted word.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] PATTERN = 16'hA5A5;

    logic        clk;
    logic        rst_n;
    logic        MEM_req;
    logic [15:0] MEM_addr;
    logic        MEM_ack;
    logic [15:0] MEM_data;
    logic [15:0] INS;
    logic [15:0] INS_addr;
    logic        INS_valid;
    logic        INS_ready;
    logic        load_pc;
    logic [15:0] new_pc;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instruction_fetch_unit #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MEM_req   (MEM_req),
        .MEM_addr  (MEM_addr),
        .MEM_ack   (MEM_ack),
        .MEM_data  (MEM_data),
        .INS       (INS),
        .INS_addr  (INS_addr),
        .INS_valid (INS_valid),
        .INS_ready (INS_ready),
        .load_pc   (load_pc),
        .new_pc    (new_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Program memory model: ack after mem_tgt wait cycles of a held request.
    // ------------------------------------------------------------------------
    int unsigned wait_min = 0;
    int unsigned wait_max = 0;
    int unsigned mem_cnt;
    int unsigned mem_tgt;

    assign MEM_ack  = MEM_req && (mem_cnt == mem_tgt);
    assign MEM_data = MEM_addr ^ PATTERN;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt <= 0;
            mem_tgt <= wait_min;
        end else if (MEM_ack) begin
            mem_cnt <= 0;
            mem_tgt <= $urandom_range(wait_max, wait_min);
        end else if (MEM_req) begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Stream scoreboard + memory handshake checks, sampled mid-cycle.
    // ------------------------------------------------------------------------
    logic [15:0] exp_addr;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;
    int unsigned accepts = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr = RST_PC;
            prev_req = 1'b0;
            prev_ack = 1'b0;
            prev_addr = '0;
        end else begin
            if (prev_req && !prev_ack) begin
                check("mem_req_held", MEM_req, 1);
                check("mem_addr_held", MEM_addr, prev_addr);
            end
            if (load_pc) begin
                exp_addr = new_pc;
            end else if (INS_valid && INS_ready) begin
                check("stream_addr", INS_addr, exp_addr);
                check("stream_data", INS, exp_addr ^ PATTERN);
                exp_addr = exp_addr + 16'd1;
                accepts++;
            end
            prev_req  = MEM_req;
            prev_ack  = MEM_ack;
            prev_addr = MEM_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset with fixed wait states; returns at cycle 0 (first cycle out of reset).
    task automatic do_reset(input int unsigned w);
        wait_min = w;
        wait_max = w;
        load_pc  = 1'b0;
        new_pc   = '0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit          found;

        INS_ready = 1'b1;
        load_pc   = 1'b0;
        new_pc    = '0;
        rst_n     = 1'b0;

        // 1: zero-wait streaming from reset
        INS_ready = 1'b1;
        do_reset(0);
        check("t1_c0_req", MEM_req, 0);
        check("t1_c0_valid", INS_valid, 0);
        check("t1_c0_mem_addr", MEM_addr, RST_PC);
        check("t1_c0_ins", INS, 0);
        check("t1_c0_ins_addr", INS_addr, 0);
        cyc();
        check("t1_c1_req", MEM_req, 1);
        check("t1_c1_mem_addr", MEM_addr, RST_PC);
        check("t1_c1_valid", INS_valid, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("t1_valid", INS_valid, 1);
            check("t1_addr", INS_addr, 16'(i));
            check("t1_data", INS, 16'(i) ^ PATTERN);
        end

        // 2: three wait states, one instruction per four cycles
        do_reset(3);
        n = 0;
        for (int c = 1; c <= 44; c++) begin
            cyc();
            if (INS_valid && INS_ready) n++;
            if (c == 5) check("t2_first_valid", INS_valid, 1);
            if (c == 6) check("t2_gap_invalid", INS_valid, 0);
        end
        check("t2_rate", n, 10);

        // 3: consumer stalled, FIFO fills to two and fetch stops
        INS_ready = 1'b0;
        do_reset(0);
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c >= 2) check("t3_hold_addr", INS_addr, 0);
            if (c >= 3) check("t3_req_off", MEM_req, 0);
        end
        check("t3_valid", INS_valid, 1);
        cyc();
        INS_ready = 1'b1;
        check("t3_rel0", INS_addr, 0);
        cyc();
        check("t3_rel1", INS_addr, 1);
        cyc();
        check("t3_rel2", INS_addr, 2);

        // 4: redirect while a request is outstanding (two wait states)
        do_reset(2);
        cyc();
        cyc();
        check("t4_outstanding", MEM_req & ~MEM_ack, 1);
        load_pc = 1'b1;
        new_pc  = 16'h0040;
        cyc();
        load_pc = 1'b0;
        check("t4_flush_valid", INS_valid, 0);
        check("t4_flush_addr", MEM_addr, 16'h0000);
        cyc();
        check("t4_new_req", MEM_req, 1);
        check("t4_new_addr", MEM_addr, 16'h0040);
        for (int c = 0; c < 2; c++) begin
            cyc();
            check("t4_wait_invalid", INS_valid, 0);
        end
        cyc();
        check("t4_valid", INS_valid, 1);
        check("t4_addr", INS_addr, 16'h0040);

        // 5: redirect coincident with an ack
        do_reset(0);
        repeat (4) cyc();
        check("t5_ack_now", MEM_ack, 1);
        check("t5_head", INS_addr, 2);
        load_pc = 1'b1;
        new_pc  = 16'h0040;
        cyc();
        load_pc = 1'b0;
        check("t5_invalid", INS_valid, 0);
        check("t5_req_addr", MEM_addr, 16'h0040);
        cyc();
        check("t5_valid", INS_valid, 1);
        check("t5_addr", INS_addr, 16'h0040);
        check("t5_data", INS, 16'h0040 ^ PATTERN);
        cyc();
        check("t5_next", INS_addr, 16'h0041);

        // 6: wrap past 0xFFFF, then asynchronous reset mid-request
        load_pc = 1'b1;
        new_pc  = 16'hFFFE;
        cyc();
        load_pc = 1'b0;
        check("t6_invalid", INS_valid, 0);
        cyc();
        check("t6_fffe", INS_addr, 16'hFFFE);
        cyc();
        check("t6_ffff", INS_addr, 16'hFFFF);
        cyc();
        check("t6_0000", INS_addr, 16'h0000);
        check("t6_0000_data", INS, PATTERN);
        wait_min = 3;
        wait_max = 3;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cyc();
            if (MEM_req && !MEM_ack) found = 1'b1;
        end
        check("t6_found_pending", found, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", MEM_req, 0);
        check("t6_rst_mem_addr", MEM_addr, RST_PC);
        check("t6_rst_ins", INS, 0);
        check("t6_rst_ins_addr", INS_addr, 0);
        check("t6_rst_valid", INS_valid, 0);

        // Randomized phase: random wait states, backpressure and redirects
        do_reset(0);
        wait_max = 3;
        accepts  = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            INS_ready = ($urandom_range(9, 0) < 7);
            load_pc   = ($urandom_range(31, 0) == 0);
            if ($urandom_range(1, 0) == 1) new_pc = 16'hFFF8 + 16'($urandom_range(7, 0));
            else                           new_pc = 16'($urandom);
        end
        load_pc = 1'b0;
        cyc();
        check("rand_progress", (accepts > 200) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
